// File: rtl/types_pkg.sv
// Shared issue-side types for the integer-M pipe: RS payload, FU ids and
// the M-extension func3 encodings used by the multiply/divide unit.
package types_pkg;

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_BRANCH = 3'd1,
        FU_LSU    = 3'd2,
        FU_MULDIV = 3'd3
    } fu_t;

    typedef struct packed {
        fu_t        fu;
        logic [2:0] func3;
        logic [6:0] ps1;
        logic [6:0] ps2;
        logic [6:0] pd;
        logic [4:0] rob_index;
    } rs_data;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        MD_IDLE  = 3'd0,
        MD_MUL   = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVSP = 3'd3,
        MD_DONE  = 3'd4
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_fu_div.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on operand
// magnitudes, signs restored on the final step.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);

    logic            busy;
    logic [CW-1:0]   count;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] quo, rem, dvsr;
    logic [XLEN:0]   trial, diff;
    logic            q_bit;
    logic [XLEN-1:0] quo_nx, rem_nx;

    function automatic logic [XLEN-1:0] mag(input logic sgn, input logic [XLEN-1:0] v);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    // quo starts as the dividend and shifts quotient bits in from the right
    always_comb begin
        trial  = {rem, quo[XLEN-1]};
        diff   = trial - {1'b0, dvsr};
        q_bit  = !diff[XLEN];
        rem_nx = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
        quo_nx = {quo[XLEN-2:0], q_bit};
    end

    assign done      = busy && (count == '0);
    assign quotient  = neg_q ? -quo_nx : quo_nx;
    assign remainder = neg_r ? -rem_nx : rem_nx;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CW'(XLEN - 1);
        end else if (busy) begin
            if (count == '0) busy <= 1'b0;
            else             count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            quo   <= mag(is_signed, dividend);
            rem   <= '0;
            dvsr  <= mag(is_signed, divisor);
            neg_q <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r <= is_signed && dividend[XLEN-1];
        end else if (busy) begin
            quo <= quo_nx;
            rem <= rem_nx;
        end
    end

endmodule

// File: rtl/muldiv_fu.sv
// Integer-M multiply/divide functional unit: 2-cycle multiply, iterative
// divide, result held for the CDB with mispredict kill by ROB age.
module muldiv_fu import types_pkg::*; #(
    parameter int XLEN      = 32,
    parameter int ROB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  rs_data          data_in,
    input  logic            fu_issued,
    output logic            fu_ready,
    output logic [6:0]      ps1_addr,
    output logic [6:0]      ps2_addr,
    input  logic [XLEN-1:0] ps1_data,
    input  logic [XLEN-1:0] ps2_data,
    input  logic            mispredict,
    input  logic [4:0]      mispredict_tag,
    input  logic [4:0]      rob_head,
    output logic            wb_valid,
    output logic [6:0]      wb_pd,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rob_index,
    input  logic            wb_grant
);

    muldiv_state_t state, state_next;

    logic [6:0]      pd_r;
    logic [4:0]      rob_r;
    logic [2:0]      f3_r;
    logic [XLEN-1:0] a_r, b_r, result_r;

    // age relative to the ROB head, so the wrap point never confuses order
    function automatic logic [4:0] rob_age(input logic [4:0] idx, input logic [4:0] head);
        return (idx - head) & 5'(ROB_DEPTH - 1);
    endfunction

    logic issue_kill, inflight_kill, accept;
    assign issue_kill    = mispredict && (rob_age(data_in.rob_index, rob_head) > rob_age(mispredict_tag, rob_head));
    assign inflight_kill = (state != MD_IDLE) && mispredict &&
                           (rob_age(rob_r, rob_head) > rob_age(mispredict_tag, rob_head));
    assign accept        = (state == MD_IDLE) && fu_issued && !issue_kill;

    assign ps1_addr = data_in.ps1;
    assign ps2_addr = data_in.ps2;

    logic            is_div_in, in_signed, div_zero, div_ovf, div_special;
    logic [XLEN-1:0] special_res;
    assign is_div_in   = data_in.func3[2];
    assign in_signed   = !data_in.func3[0];
    assign div_zero    = (ps2_data == '0);
    assign div_ovf     = in_signed && (ps1_data == {1'b1, {(XLEN-1){1'b0}}}) && (ps2_data == '1);
    assign div_special = is_div_in && (div_zero || div_ovf);

    // func3[1] selects remainder over quotient for the divide group
    always_comb begin
        special_res = '0;
        if (div_zero) special_res = data_in.func3[1] ? ps1_data : '1;
        else          special_res = data_in.func3[1] ? '0 : ps1_data;
    end

    logic                     a_sgn, b_sgn;
    logic signed [XLEN:0]     a_ext, b_ext;
    logic signed [2*XLEN+1:0] prod;
    assign a_sgn = (f3_r != F3_MULHU);
    assign b_sgn = (f3_r == F3_MUL) || (f3_r == F3_MULH);
    assign a_ext = {a_sgn & a_r[XLEN-1], a_r};
    assign b_ext = {b_sgn & b_r[XLEN-1], b_r};
    assign prod  = (2*XLEN+2)'(a_ext) * (2*XLEN+2)'(b_ext);

    logic unused_bits;
    assign unused_bits = ^{data_in.fu, prod[2*XLEN+1:2*XLEN]};

    logic            div_done;
    logic [XLEN-1:0] div_q, div_r;

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (accept && is_div_in && !div_special),
        .abort     (inflight_kill),
        .is_signed (in_signed),
        .dividend  (ps1_data),
        .divisor   (ps2_data),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        state_next = state;
        fu_ready   = 1'b0;
        case (state)
            MD_IDLE: begin
                fu_ready = !fu_issued;
                if (accept) begin
                    if (!is_div_in)      state_next = MD_MUL;
                    else if (div_special) state_next = MD_DIVSP;
                    else                  state_next = MD_DIV;
                end
            end
            MD_MUL, MD_DIVSP: state_next = MD_DONE;
            MD_DIV:           if (div_done) state_next = MD_DONE;
            MD_DONE:          if (wb_grant) state_next = MD_IDLE;
            default:          state_next = MD_IDLE;
        endcase
        if (inflight_kill) state_next = MD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MD_IDLE;
            pd_r     <= '0;
            rob_r    <= '0;
            result_r <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pd_r  <= data_in.pd;
                rob_r <= data_in.rob_index;
            end
            if (accept && div_special)
                result_r <= special_res;
            else if (state == MD_MUL)
                result_r <= (f3_r == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            else if (state == MD_DIV && div_done)
                result_r <= f3_r[1] ? div_r : div_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            f3_r <= data_in.func3;
            a_r  <= ps1_data;
            b_r  <= ps2_data;
        end
    end

    // a kill in the DONE cycle must win over a same-cycle grant
    assign wb_valid     = (state == MD_DONE) && !inflight_kill;
    assign wb_pd        = pd_r;
    assign wb_rob_index = rob_r;
    assign wb_data      = result_r;

endmodule

// File: tb/tb_muldiv_fu.sv
// Bench for muldiv_fu: directed M-extension cases plus randomized traffic,
// all checked against an arithmetic reference model of the unit.
module tb_muldiv_fu;
    import types_pkg::*;

    logic        clk = 1'b0;
    logic        reset, fu_issued, fu_ready, mispredict, wb_valid, wb_grant;
    rs_data      data_in;
    logic [6:0]  ps1_addr, ps2_addr, wb_pd;
    logic [31:0] ps1_data, ps2_data, wb_data;
    logic [4:0]  mispredict_tag, rob_head, wb_rob_index;
    logic [31:0] prf [128];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    assign ps1_data = prf[ps1_addr];
    assign ps2_data = prf[ps2_addr];

    muldiv_fu dut (
        .clk(clk), .reset(reset), .data_in(data_in), .fu_issued(fu_issued),
        .fu_ready(fu_ready), .ps1_addr(ps1_addr), .ps2_addr(ps2_addr),
        .ps1_data(ps1_data), .ps2_data(ps2_data), .mispredict(mispredict),
        .mispredict_tag(mispredict_tag), .rob_head(rob_head), .wb_valid(wb_valid),
        .wb_pd(wb_pd), .wb_data(wb_data), .wb_rob_index(wb_rob_index), .wb_grant(wb_grant)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] up;
        int          ia, ib, r;
        sa = $signed(a);
        sb = $signed(b);
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (f)
            F3_MUL:    begin p = sa * sb; return p[31:0]; end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = ia / ib; return r;
            end
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = ia % ib; return r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f < 3'd4) return 2;
        if (b == 0) return 2;
        if ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    function automatic bit killed(input logic [4:0] idx);
        int di, dt;
        di = (int'(idx) - int'(rob_head) + 32) % 16;
        dt = (int'(mispredict_tag) - int'(rob_head) + 32) % 16;
        return mispredict && (di > dt);
    endfunction

    bit          m_busy = 1'b0;
    int          m_age, m_lat;
    logic [6:0]  m_pd;
    logic [4:0]  m_rob;
    logic [31:0] m_data;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (killed(m_rob))                      m_busy <= 1'b0;
            else if (m_age >= m_lat && wb_grant)    m_busy <= 1'b0;
            else if (m_age < m_lat)                 m_age  <= m_age + 1;
        end else if (fu_issued && !killed(data_in.rob_index)) begin
            m_busy <= 1'b1;
            m_age  <= 1;
            m_pd   <= data_in.pd;
            m_rob  <= data_in.rob_index;
            m_lat  <= ref_lat(data_in.func3, prf[data_in.ps1], prf[data_in.ps2]);
            m_data <= ref_res(data_in.func3, prf[data_in.ps1], prf[data_in.ps2]);
        end
    end

    // ---------------- compare process ----------------
    bit exp_valid;
    always @(negedge clk) begin
        if (chk_on && !reset) begin
            exp_valid = m_busy && (m_age >= m_lat) && !killed(m_rob);
            chk("fu_ready", fu_ready, !m_busy && !fu_issued);
            chk("wb_valid", wb_valid, exp_valid);
            chk("ps1_addr", ps1_addr, data_in.ps1);
            chk("ps2_addr", ps2_addr, data_in.ps2);
            if (exp_valid) begin
                chk("wb_data", wb_data, m_data);
                chk("wb_pd", wb_pd, m_pd);
                chk("wb_rob_index", wb_rob_index, m_rob);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [6:0] pd, input logic [4:0] rob);
        prf[1]    = a;
        prf[2]    = b;
        data_in   = '{fu: FU_MULDIV, func3: f, ps1: 7'd1, ps2: 7'd2, pd: pd, rob_index: rob};
        fu_issued = 1'b1;
        @(negedge clk);
        chk("ready_low_at_issue", fu_ready, 1'b0);
        @(posedge clk); #1;
        fu_issued = 1'b0;
    endtask

    task automatic wait_wb(input string nm, input int exp_lat, input logic [31:0] exp_data);
        int cnt;
        bit seen;
        cnt  = 1;
        seen = 1'b0;
        while (cnt <= 60) begin
            @(negedge clk);
            if (wb_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cnt++;
        end
        chk({nm, "_seen"}, seen, 1'b1);
        chk({nm, "_latency"}, cnt, exp_lat);
        chk({nm, "_data"}, wb_data, exp_data);
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [6:0] pd, input int lat, input logic [31:0] exp_data);
        issue_op(f, a, b, pd, 5'd4);
        wait_wb(nm, lat, exp_data);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_data;
        logic [6:0]  held_pd;
        int          vcount;

        reset = 1'b1; fu_issued = 1'b0; data_in = '0; mispredict = 1'b0;
        mispredict_tag = '0; rob_head = '0; wb_grant = 1'b1;
        for (int i = 0; i < 128; i++) prf[i] = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_ready", fu_ready, 1'b1);
        chk("reset_valid", wb_valid, 1'b0);
        @(posedge clk); #1;

        // model pins against hand-computed values
        chk("pin_mul", ref_res(F3_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("pin_mulhsu", ref_res(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("pin_rem", ref_res(F3_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_lat_div", ref_lat(F3_DIVU, 32'd100, 32'd7), 33);

        // multiply group, grant held high
        issue_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 7'd5, 5'd3);
        wait_wb("mul", 2, 32'hFFFF_FFEB);
        chk("mul_pd", wb_pd, 7'd5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_grant", fu_ready, 1'b1);
        @(posedge clk); #1;
        run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd6, 2, 32'hFFFF_FFFE);
        run_op("mulh",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd0, 2, 32'h0000_0000);
        run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd7, 2, 32'hFFFF_FFFF);

        // divide group and special cases
        run_op("div",    F3_DIV,  32'hFFFF_FFF9, 32'd2, 7'd8, 33, 32'hFFFF_FFFD);
        run_op("rem",    F3_REM,  32'hFFFF_FFF9, 32'd2, 7'd9, 33, 32'hFFFF_FFFF);
        run_op("divu",   F3_DIVU, 32'd100, 32'd7, 7'd10, 33, 32'd14);
        run_op("div0",   F3_DIV,  32'd55, 32'd0, 7'd11, 2, 32'hFFFF_FFFF);
        run_op("removf", F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 7'd12, 2, 32'd0);

        // writeback held while grant is low
        wb_grant = 1'b0;
        issue_op(F3_DIVU, 32'd1000, 32'd10, 7'd13, 5'd6);
        wait_wb("hold", 33, 32'd100);
        held_data = wb_data;
        held_pd   = wb_pd;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", wb_valid, 1'b1);
            chk("hold_data", wb_data, held_data);
            chk("hold_pd", wb_pd, held_pd);
            chk("hold_ready", fu_ready, 1'b0);
        end
        wb_grant = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_late_grant", fu_ready, 1'b1);
        @(posedge clk); #1;

        // younger divide killed by mispredict
        rob_head = 5'd14;
        issue_op(F3_DIV, 32'd1000, 32'd3, 7'd14, 5'd2);
        mispredict = 1'b1; mispredict_tag = 5'd0;
        @(negedge clk);
        chk("kill_valid_low", wb_valid, 1'b0);
        @(posedge clk); #1;
        mispredict = 1'b0;
        @(negedge clk);
        chk("ready_after_kill", fu_ready, 1'b1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (wb_valid) vcount++;
        end
        chk("killed_never_valid", vcount, 0);
        @(posedge clk); #1;

        // older branch: op survives a standing mispredict
        issue_op(F3_DIV, 32'd1000, 32'd3, 7'd15, 5'd2);
        mispredict = 1'b1; mispredict_tag = 5'd3;
        wait_wb("survive", 33, 32'd333);
        @(posedge clk); #1;
        mispredict = 1'b0; rob_head = 5'd0;

        // kill in DONE beats a grant
        issue_op(F3_DIV, 32'd9, 32'd0, 7'd16, 5'd5);
        @(posedge clk); #1;
        mispredict = 1'b1; mispredict_tag = 5'd2;
        @(negedge clk);
        chk("done_kill_valid", wb_valid, 1'b0);
        @(posedge clk); #1;
        mispredict = 1'b0;
        @(negedge clk);
        chk("done_kill_ready", fu_ready, 1'b1);
        @(posedge clk); #1;

        // issue dropped in a kill cycle
        mispredict = 1'b1; mispredict_tag = 5'd1;
        issue_op(F3_MUL, 32'd3, 32'd3, 7'd17, 5'd9);
        mispredict = 1'b0;
        @(negedge clk);
        chk("dropped_ready", fu_ready, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("dropped_valid", wb_valid, 1'b0);
        @(posedge clk); #1;

        // reset in the middle of a divide
        issue_op(F3_DIVU, 32'd77777, 32'd3, 7'd18, 5'd7);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", fu_ready, 1'b1);
        chk("rst_valid", wb_valid, 1'b0);
        chk("rst_pd", wb_pd, 7'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_rob", wb_rob_index, 5'd0);
        @(posedge clk); #1;
        run_op("mul_after_rst", F3_MUL, 32'd6, 32'd7, 7'd19, 2, 32'd42);

        // randomized traffic against the model
        for (int c = 0; c < 20000; c++) begin
            logic [6:0] r1, r2;
            wb_grant       = ($urandom_range(0, 2) != 0);
            mispredict     = ($urandom_range(0, 24) == 0);
            mispredict_tag = 5'($urandom);
            rob_head       = 5'($urandom);
            if (!m_busy && $urandom_range(0, 2) == 0) begin
                r1 = 7'($urandom_range(1, 63));
                r2 = 7'($urandom_range(64, 127));
                prf[r1] = pick();
                prf[r2] = pick();
                data_in = '{fu: FU_MULDIV, func3: 3'($urandom), ps1: r1, ps2: r2,
                            pd: 7'($urandom), rob_index: 5'($urandom)};
                fu_issued = 1'b1;
            end else begin
                fu_issued = 1'b0;
            end
            @(posedge clk); #1;
        end
        fu_issued = 1'b0; mispredict = 1'b0; wb_grant = 1'b1;
        repeat (40) begin @(posedge clk); #1; end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_fu.md
# muldiv_fu

Multiply/divide functional unit at the issue end of the integer-M reservation station. It accepts one `rs_data` entry per issue handshake and reads both source operands from the physical register file. Multiplies finish in 2 cycles; divides and remainders use an iterative radix-2 divider. The result is held on a writeback port until the CDB arbiter grants it, and an in-flight op is killed when a mispredict makes it younger than the branch.

## Interface
- `XLEN`, 32: operand/result width.
- `ROB_DEPTH`, 16: ROB entries; tag arithmetic is modulo this.
- Reset is synchronous and active-high; single clock `clk`.
- `clk` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `data_in` in `rs_data`: registered issue payload from the RS.
- `fu_issued` in 1: `data_in` valid this cycle.
- `fu_ready` out 1: FU can accept an issue at the next edge.
- `ps1_addr`, `ps2_addr` out 7: PRF read addresses, combinational from `data_in.ps1`/`ps2`.
- `ps1_data`, `ps2_data` in XLEN: PRF read data, same cycle.
- `mispredict` in 1: branch mispredict pulse.
- `mispredict_tag` in 5: ROB index of the mispredicted branch.
- `rob_head` in 5: current ROB head, used for age comparison.
- `wb_valid` out 1: result available.
- `wb_pd` out 7: destination preg.
- `wb_data` out XLEN: result.
- `wb_rob_index` out 5: ROB entry to mark complete.
- `wb_grant` in 1: CDB arbiter accepts the result this cycle.

## Operation
- Ops are decoded from `func3` (M extension):
  - 000 MUL, low 32 bits of the product.
  - 001 MULH, signed×signed, high word.
  - 010 MULHSU, signed×unsigned, high word.
  - 011 MULHU, unsigned×unsigned, high word.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States:
  - IDLE: `fu_ready = !fu_issued`. If `fu_issued` and the op is not killed, latch `pd`, `rob_index`, `func3` and both operands, then go to MUL (func3<4), DIVSP (a division special case), or DIV.
  - MUL: form the 66-bit signed product of sign/zero-extended operands into a register; go to DONE.
  - DIV: restoring divide on magnitudes, one quotient bit per cycle, 5-bit counter 31→0; at 0 apply the sign fix and go to DONE.
  - DIVSP: result already computed; go to DONE.
  - DONE: `wb_valid=1`. On `wb_grant`, go to IDLE.
- Division special cases:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (−2^31 / −1): quotient = −2^31; remainder = 0.
- Sign fix: quotient is negated when the operand signs differ (signed ops only); remainder takes the dividend's sign.
- Kill: the op is killed when `mispredict` is high and `(rob_index − rob_head) mod 16 > (mispredict_tag − rob_head) mod 16`.
  - A killed in-flight op goes to IDLE at the next edge.
  - `wb_valid` is combinationally forced to 0 in the kill cycle, so kill beats `wb_grant`.
  - An issue that arrives in a kill cycle is checked the same way; if killed it is dropped and the FU stays IDLE.
- `pd==0` is written back normally; the PRF ignores writes to p0.

## Timing
- Issue cycle T: `fu_issued=1`, `fu_ready` low combinationally. The RS registers its output, so `fu_ready` must drop in the same cycle as `fu_issued` to prevent a back-to-back issue.
- Latency to `wb_valid`:
  - MUL ops: T+2.
  - Divide special cases: T+2.
  - DIV/REM: T+33.
- DONE holds `wb_*` stable until the `wb_grant` edge. `fu_ready` returns the cycle after the grant.
- Max throughput: one MUL per 3 cycles with immediate grant.
- Reset, including mid-operation, leaves: state IDLE, `fu_ready=1`, `wb_valid=0`, `wb_pd=0`, `wb_data=0`, `wb_rob_index=0`, counter 0.

## Structure
- `types_pkg` additions:
  - `F3_MUL`…`F3_REMU` constants.
  - `muldiv_state_t` enum.
  - `FU_MULDIV` id for the `fu` field.
- Sub-module `div_iter`: start/done handshake, signed flag, operands in; quotient and remainder out. It owns the counter and the sign fix.
- Multiply stays inline in `muldiv_fu`.

## Test plan
- MUL 7×(−3), grant held high → `wb_valid` at T+2, `wb_data=0xFFFFFFEB`; `fu_ready` low at T and high at T+3.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → `0xFFFFFFFE`. MULH same operands → `0x00000000`. MULHSU −1×0xFFFFFFFF → `0xFFFFFFFF`.
- DIV −7/2 → −3; REM → −1; DIVU 100/7 → 14 at T+33. DIV by 0 → `0xFFFFFFFF`. REM 0x80000000/−1 → 0, at T+2.
- Hold `wb_grant=0` for 5 cycles in DONE → `wb_*` stable and `fu_ready=0` throughout; grant → IDLE.
- rob_head=14, op rob_index=2, mispredict_tag=0 during DIV → killed, `wb_valid` never asserted, `fu_ready` next cycle. Same stimulus with tag=3 → op completes.
- Assert `reset` at cycle 10 of a DIV → all outputs at reset values next cycle; a new MUL issued afterwards completes normally.
